lsu_mem_master: RTL

- Load/store unit: the initiator side of the data-memory port used by the RISC-V core.
- Accepts one load/store request at a time from the execute stage. Drives a word-addressed memory port: combinational read, write on the posedge of clk while WE is high. Returns load data or store completion on a one-cycle response strobe.
- Supports byte, half and word accesses. Sub-word stores are done as read-modify-write; sub-word loads are extracted and sign/zero extended.
- Stalls the core while busy.

---
 rtl/lsu_mem_master_if.sv | 34 +++
 rtl/lsu_mem_master.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_mem_master_if : request/response and word-memory port bundle of the LSU |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface lsu_mem_master_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    logic             busy;
    logic             mem_we;
    logic [WIDTH-1:0] mem_a;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] mem_rd;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy, mem_we, mem_a, mem_wd
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy, mem_we, mem_a, mem_wd
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_mem_master : RV32I load/store unit driving a word-addressed data memory |
// | Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lsu_mem_master #(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    lsu_mem_master_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_f3;
    logic [1:0]       r_lane;
    logic [15:0]      r_wdata;
    logic             r_rmw;
    logic [WIDTH-1:0] r_mem_a;
    logic [WIDTH-1:0] r_mem_wd;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_rdata;
    logic             r_rsp_err;

    logic             w_illegal;
    logic             w_misalign;
    logic             w_err;
    logic [WIDTH-1:0] w_shift;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_merged;

    assign w_illegal = bus.req_we ? (bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'd3))
                                  : ((bus.req_funct3[1:0] == 2'd3) | (bus.req_funct3 == 3'd6));

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'd0));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = w_illegal | w_misalign;

    // Sub-word load extraction from the word currently on mem_rd
    assign w_shift = bus.mem_rd >> {r_lane, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = r_lane[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

    always_comb begin
        w_load = bus.mem_rd;
        case (r_f3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd4:    w_load = {24'd0, w_byte};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = bus.mem_rd;
        endcase
    end

    always_comb begin
        w_merged = bus.mem_rd;
        if (r_f3[0]) begin
            if (r_lane[1]) w_merged[31:16] = r_wdata;
            else           w_merged[15:0]  = r_wdata;
        end else begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_f3        <= 3'd0;
            r_lane      <= 2'd0;
            r_wdata     <= 16'd0;
            r_rmw       <= 1'b0;
            r_mem_a     <= '0;
            r_mem_wd    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_f3    <= bus.req_funct3;
                        r_lane  <= bus.req_addr[1:0];
                        r_wdata <= bus.req_wdata[15:0];
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end else begin
                            r_mem_a <= {bus.req_addr[WIDTH-1:2], 2'b00};
                            if (!bus.req_we) begin
                                r_rmw   <= 1'b0;
                                r_state <= S_RD;
                            end else if (bus.req_funct3[1:0] == 2'd2) begin
                                r_rmw    <= 1'b0;
                                r_mem_wd <= bus.req_wdata;
                                r_state  <= S_WR;
                            end else begin
                                r_rmw   <= 1'b1;
                                r_state <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (r_rmw) begin
                        r_mem_wd <= w_merged;
                        r_state  <= S_WR;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= w_load;
                        r_state     <= S_RESP;
                    end
                end
                S_WR: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_state     <= S_RESP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE) && !reset;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.mem_we    = (r_state == S_WR);
    assign bus.mem_a     = r_mem_a;
    assign bus.mem_wd    = r_mem_wd;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
